branch_spec_ctrl: RTL and testbench

- Speculation controller in front of the branch unit.
- Admits branch/jump issue from the issue stage only while the number of unresolved branches is below a limit.
- Retires entries as the branch unit resolves them.
- On a mispredict, sequences a fixed-length flush plus a one-shot PC redirect to the frontend.
- Sits between the issue stage, the branch unit's resolve outputs, and the frontend/controller flush lines.

---
 rtl/branch_spec_ctrl_if.sv | 35 +++
 rtl/branch_spec_ctrl.sv | 130 +++++++++++++
 tb/tb_branch_spec_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_spec_ctrl_if.sv
// Branch speculation controller bus.
// Groups the issue handshake, the branch-unit resolve lines and the
// frontend flush/redirect lines of branch_spec_ctrl.
//
// Handshake: a branch issues on a rising clk edge where issue_valid_i and
// issue_ready_o are both high. issue_ready_o never depends combinationally
// on issue_valid_i or on any resolve_* line. resolve_valid_i is a
// single-cycle strobe with no back-pressure; resolve_mispredict_i and
// resolve_target_i are meaningful only while it is high.
//
// Modports:
//   master - issue stage / branch unit / frontend side (drives valid, resolve)
//   slave  - the controller
interface branch_spec_ctrl_if #(
  parameter int VLEN = 64
);
  logic            issue_valid_i;
  logic            issue_ready_o;
  logic            resolve_valid_i;
  logic            resolve_mispredict_i;
  logic [VLEN-1:0] resolve_target_i;
  logic            flush_o;
  logic            redirect_valid_o;
  logic [VLEN-1:0] redirect_pc_o;

  modport master (
    output issue_valid_i, resolve_valid_i, resolve_mispredict_i, resolve_target_i,
    input  issue_ready_o, flush_o, redirect_valid_o, redirect_pc_o
  );

  modport slave (
    input  issue_valid_i, resolve_valid_i, resolve_mispredict_i, resolve_target_i,
    output issue_ready_o, flush_o, redirect_valid_o, redirect_pc_o
  );
endinterface

// File: rtl/branch_spec_ctrl.sv
// Branch speculation controller.
// Tracks the number of unresolved branches, admits new branch issue only
// while that number is below the limit (1 in debug mode, NR_SPEC otherwise),
// retires entries on resolve, and on a mispredict runs a FLUSH_CYCLES-long
// flush with a one-cycle PC redirect.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   debug_mode_i     forces the outstanding limit to 1
//   bus              branch_spec_ctrl_if.slave (issue / resolve / flush / redirect)
//   spec_cnt_o       registered unresolved-branch count
//   err_o            one-cycle pulse: resolve arrived with nothing outstanding
//   mispredict_cnt_o saturating mispredict count (0 unless stats are built)
//   dbg_state_o      FSM state, 0 = RUN, 1 = FLUSH
//
// Optional feature: define BRANCH_SPEC_STATS_EN to build the mispredict
// statistics counter.
module branch_spec_ctrl #(
  parameter int NR_SPEC      = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int VLEN         = 64,
  localparam int CW          = $clog2(NR_SPEC + 1),
  localparam int FW          = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                debug_mode_i,
  branch_spec_ctrl_if.slave   bus,
  output logic [CW-1:0]       spec_cnt_o,
  output logic                err_o,
  output logic [31:0]         mispredict_cnt_o,
  output logic                dbg_state_o
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [FW-1:0]   flush_cnt;
  logic            flush;
  logic            redirect_valid;
  logic [VLEN-1:0] redirect_pc;
  logic            err;

  logic [CW-1:0]   lim;
  logic            ready;
  logic            fire;
  logic            res_ok;
  logic            res_mis;

  assign lim     = debug_mode_i ? CW'(1) : CW'(NR_SPEC);
  // Built from registered state and debug/reset only, never from resolve_*.
  assign ready   = !rst_i && (state == RUN) && (count < lim);
  assign fire    = bus.issue_valid_i && ready;
  assign res_ok  = bus.resolve_valid_i && !bus.resolve_mispredict_i;
  assign res_mis = bus.resolve_valid_i && bus.resolve_mispredict_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= RUN;
      count          <= '0;
      flush_cnt      <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      err            <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      err            <= 1'b0;
      case (state)
        RUN: begin
          if (bus.resolve_valid_i && (count == '0) && !fire) begin
            // Nothing outstanding to resolve: flag it, otherwise ignore.
            err <= 1'b1;
          end else if (res_mis && (count != '0)) begin
            // A same-cycle fire is younger than the mispredicted branch and
            // is dropped along with everything else outstanding.
            state          <= FLUSH;
            count          <= '0;
            flush          <= 1'b1;
            flush_cnt      <= FW'(FLUSH_CYCLES - 1);
            redirect_valid <= 1'b1;
            redirect_pc    <= bus.resolve_target_i;
          end else if (fire && !res_ok) begin
            count <= count + CW'(1);
          end else if (res_ok && !fire) begin
            count <= count - CW'(1);
          end
        end
        FLUSH: begin
          // Resolves seen here belong to squashed younger branches.
          if (flush_cnt == '0) begin
            state <= RUN;
            flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - FW'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef BRANCH_SPEC_STATS_EN
  logic [31:0] mis_cnt;

  // Counts at the same edge that raises redirect_valid_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mis_cnt <= '0;
    end else if ((state == RUN) && res_mis && (count != '0) && (mis_cnt != 32'hFFFF_FFFF)) begin
      mis_cnt <= mis_cnt + 32'd1;
    end
  end

  assign mispredict_cnt_o = mis_cnt;
`else
  assign mispredict_cnt_o = 32'd0;
`endif

  assign bus.issue_ready_o    = ready;
  assign bus.flush_o          = flush;
  assign bus.redirect_valid_o = redirect_valid;
  assign bus.redirect_pc_o    = redirect_pc;
  assign spec_cnt_o           = count;
  assign err_o                = err;
  assign dbg_state_o          = state;

endmodule

// File: tb/tb_branch_spec_ctrl.sv
// Testbench for branch_spec_ctrl: directed vectors, a cycle-level model of
// the outstanding-branch bookkeeping checked on every falling edge, and
// literal expectations at the key points of each scenario.
module tb_branch_spec_ctrl;
  localparam int NR_SPEC      = 4;
  localparam int FLUSH_CYCLES = 2;
  localparam int VLEN         = 64;
  localparam int CW           = $clog2(NR_SPEC + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic debug_mode = 1'b0;
  always #5 clk = ~clk;

  branch_spec_ctrl_if #(.VLEN(VLEN)) bus ();

  logic [CW-1:0] spec_cnt;
  logic          err;
  logic [31:0]   mis_cnt;
  logic          dbg_state;

  branch_spec_ctrl #(.NR_SPEC(NR_SPEC), .FLUSH_CYCLES(FLUSH_CYCLES), .VLEN(VLEN)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .debug_mode_i     (debug_mode),
    .bus              (bus.slave),
    .spec_cnt_o       (spec_cnt),
    .err_o            (err),
    .mispredict_cnt_o (mis_cnt),
    .dbg_state_o      (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Remaining flush cycles including the current one; zero means running.
  int          m_cnt = 0;
  int          m_flush_left = 0;
  bit          m_rv = 0;
  bit          m_err = 0;
  logic [63:0] m_pc = '0;
  longint      m_mis = 0;
  bit          chk_en = 0;

  function automatic bit m_ready();
    int lim;
    lim = debug_mode ? 1 : NR_SPEC;
    return !rst && (m_flush_left == 0) && (m_cnt < lim);
  endfunction

  always @(posedge clk) begin
    bit fire;
    fire = bus.issue_valid_i && m_ready();
    m_rv = 0;
    m_err = 0;
    if (rst) begin
      m_cnt = 0; m_flush_left = 0; m_pc = '0; m_mis = 0;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (bus.resolve_valid_i && m_cnt == 0 && !fire) begin
      m_err = 1;
    end else if (bus.resolve_valid_i && bus.resolve_mispredict_i && m_cnt >= 1) begin
      m_flush_left = FLUSH_CYCLES;
      m_rv = 1;
      m_pc = bus.resolve_target_i;
      m_cnt = 0;
      if (m_mis < 64'hFFFF_FFFF) m_mis++;
    end else begin
      m_cnt = m_cnt + int'(fire) - int'(bus.resolve_valid_i && !bus.resolve_mispredict_i);
    end
    chk_en = 1;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ready",    64'(bus.issue_ready_o),    64'(m_ready()));
      chk("m_cnt",      64'(spec_cnt),             64'(m_cnt));
      chk("m_flush",    64'(bus.flush_o),          64'(m_flush_left > 0));
      chk("m_state",    64'(dbg_state),            64'(m_flush_left > 0));
      chk("m_redir_v",  64'(bus.redirect_valid_o), 64'(m_rv));
      chk("m_redir_pc", bus.redirect_pc_o,         m_pc);
      chk("m_err",      64'(err),                  64'(m_err));
`ifdef BRANCH_SPEC_STATS_EN
      chk("m_stats",    64'(mis_cnt),              64'(m_mis));
`else
      chk("m_stats",    64'(mis_cnt),              64'd0);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit iv, input bit rv, input bit mp, input logic [63:0] tgt);
    bus.issue_valid_i        = iv;
    bus.resolve_valid_i      = rv;
    bus.resolve_mispredict_i = mp;
    bus.resolve_target_i     = tgt;
  endtask

  task automatic idle();
    drive(0, 0, 0, 64'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    idle();
    rst = 1'b1;
    cyc(); cyc();
    chk("rst_cnt",   64'(spec_cnt), 64'd0);
    chk("rst_ready", 64'(bus.issue_ready_o), 64'd0);
    chk("rst_flush", 64'(bus.flush_o), 64'd0);
    chk("rst_pc",    bus.redirect_pc_o, 64'd0);
    rst = 1'b0;
    cyc();
    chk("run_ready", 64'(bus.issue_ready_o), 64'd1);

    // Four back-to-back issues fill the window; a fifth request stalls.
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 0, 64'd0);
      cyc();
      chk("fill_cnt", 64'(spec_cnt), 64'(i));
    end
    chk("full_ready", 64'(bus.issue_ready_o), 64'd0);
    cyc();
    chk("stall_cnt", 64'(spec_cnt), 64'd4);

    // Correct resolve frees a slot; fire + resolve together leaves it unchanged.
    drive(0, 1, 0, 64'd0);
    cyc();
    chk("res_cnt",   64'(spec_cnt), 64'd3);
    chk("res_ready", 64'(bus.issue_ready_o), 64'd1);
    drive(1, 1, 0, 64'd0);
    cyc();
    chk("both_cnt", 64'(spec_cnt), 64'd3);
    drive(0, 1, 0, 64'd0);
    cyc();
    chk("res2_cnt", 64'(spec_cnt), 64'd2);

    // Mispredict with two outstanding; a same-cycle issue is discarded.
    drive(1, 1, 1, 64'h8000_1000);
    cyc();
    chk("mis_rv",    64'(bus.redirect_valid_o), 64'd1);
    chk("mis_pc",    bus.redirect_pc_o, 64'h8000_1000);
    chk("mis_cnt",   64'(spec_cnt), 64'd0);
    chk("mis_flush", 64'(bus.flush_o), 64'd1);
    chk("mis_ready", 64'(bus.issue_ready_o), 64'd0);
    // Stale resolves during the flush are ignored.
    drive(0, 1, 0, 64'd0);
    cyc();
    chk("fl2_rv",    64'(bus.redirect_valid_o), 64'd0);
    chk("fl2_flush", 64'(bus.flush_o), 64'd1);
    chk("fl2_err",   64'(err), 64'd0);
    drive(0, 1, 1, 64'h8000_2000);
    cyc();
    chk("end_flush", 64'(bus.flush_o), 64'd0);
    chk("end_ready", 64'(bus.issue_ready_o), 64'd1);
    chk("end_pc",    bus.redirect_pc_o, 64'h8000_1000);
    chk("end_err",   64'(err), 64'd0);
    chk("end_cnt",   64'(spec_cnt), 64'd0);

    // Resolve with nothing outstanding.
    drive(0, 1, 0, 64'd0);
    cyc();
    chk("perr_err", 64'(err), 64'd1);
    chk("perr_cnt", 64'(spec_cnt), 64'd0);
    idle();
    cyc();
    chk("perr_clr", 64'(err), 64'd0);

    // Debug mode limits the window to one.
    debug_mode = 1'b1;
    drive(1, 0, 0, 64'd0);
    cyc();
    chk("dbg_cnt",   64'(spec_cnt), 64'd1);
    chk("dbg_ready", 64'(bus.issue_ready_o), 64'd0);
    debug_mode = 1'b0;
    cyc(); cyc();
    chk("dbg_fill", 64'(spec_cnt), 64'd3);
    idle();
    debug_mode = 1'b1;
    #1;
    chk("dbg_over_ready", 64'(bus.issue_ready_o), 64'd0);
    drive(0, 1, 0, 64'd0);
    cyc();
    chk("dbg_drain2", 64'(bus.issue_ready_o), 64'd0);
    cyc();
    chk("dbg_drain1", 64'(bus.issue_ready_o), 64'd0);
    cyc();
    idle();
    chk("dbg_drain0", 64'(bus.issue_ready_o), 64'd1);
    debug_mode = 1'b0;

    // Reset on the first flush cycle aborts the flush.
    drive(1, 0, 0, 64'd0);
    cyc();
    drive(0, 1, 1, 64'h8000_3000);
    cyc();
    chk("pre_rst_flush", 64'(bus.flush_o), 64'd1);
    idle();
    rst = 1'b1;
    cyc();
    chk("mrst_flush", 64'(bus.flush_o), 64'd0);
    chk("mrst_rv",    64'(bus.redirect_valid_o), 64'd0);
    chk("mrst_pc",    bus.redirect_pc_o, 64'd0);
    chk("mrst_state", 64'(dbg_state), 64'd0);
    chk("mrst_ready", 64'(bus.issue_ready_o), 64'd0);
    rst = 1'b0;
    cyc();
    chk("post_ready", 64'(bus.issue_ready_o), 64'd1);
    chk("post_stats", 64'(mis_cnt), 64'd0);

    // Mixed traffic table, checked by the model only.
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), 64'($urandom_range(0, 32'h7FFF_FFFF)));
      debug_mode = ($urandom_range(0, 9) == 0);
      cyc();
    end
    idle();
    debug_mode = 1'b0;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
